// File: rtl/cpu_sequencer.sv
// Multicycle fetch/decode/execute/write-back sequencer with run/step,
// fetch timeout, execute stalls, halt and a retired-instruction counter.
module cpu_sequencer #(
  parameter int CNT_WIDTH = 32,
  parameter int MAX_WAIT  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 step,
  input  logic                 imem_ready,
  input  logic                 is_halt,
  input  logic                 is_branch,
  input  logic                 stall_req,
  output logic [2:0]           state,
  output logic                 fetch_en,
  output logic                 pc_enable,
  output logic                 reg_write_enable,
  output logic                 halted,
  output logic                 timeout_err,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] retired
);

  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WW-1:0] LP_LAST = WW'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [WW-1:0]        r_wait;
  logic                 r_single;
  logic                 r_branch_q;
  logic [CNT_WIDTH-1:0] r_retired;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (run || step) w_next = S_FETCH;
      S_FETCH: begin
        if (imem_ready)           w_next = S_DECODE;
        else if (r_wait == LP_LAST) w_next = S_ERR;
      end
      S_DECODE: w_next = is_halt ? S_HALT : S_EXEC;
      S_EXEC:   if (!stall_req) w_next = S_WB;
      S_WB:     w_next = (r_single || !run) ? S_IDLE : S_FETCH;
      S_HALT:   w_next = S_HALT;
      S_ERR:    w_next = S_ERR;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    pc_enable        = 1'b0;
    reg_write_enable = 1'b0;
    halted           = 1'b0;
    timeout_err      = 1'b0;
    busy             = 1'b0;
    case (r_state)
      S_FETCH, S_DECODE, S_EXEC: busy = 1'b1;
      S_WB: begin
        busy             = 1'b1;
        pc_enable        = 1'b1;
        reg_write_enable = !r_branch_q;
      end
      S_HALT:  halted      = 1'b1;
      S_ERR:   timeout_err = 1'b1;
      default: ;
    endcase
  end

  // wait counter only runs across consecutive not-ready FETCH cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait <= '0;
    end else if (r_state == S_FETCH && !imem_ready) begin
      r_wait <= r_wait + WW'(1);
    end else begin
      r_wait <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_single   <= 1'b0;
      r_branch_q <= 1'b0;
      r_retired  <= '0;
    end else begin
      if (r_state == S_IDLE && run)
        r_single <= 1'b0;
      else if (r_state == S_IDLE && step)
        r_single <= 1'b1;
      else if (r_state == S_WB && w_next == S_IDLE)
        r_single <= 1'b0;
      if (r_state == S_DECODE)
        r_branch_q <= is_branch;
      if (r_state == S_WB)
        r_retired <= r_retired + CNT_WIDTH'(1);
    end
  end

  assign state    = r_state;
  assign fetch_en = (r_state == S_FETCH) && imem_ready;
  assign retired  = r_retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: free run, step, fetch wait/timeout,
// halt, branch/stall, counter wrap and asynchronous reset.
module tb_cpu_sequencer;

  localparam int CW = 4;
  localparam int MW = 16;

  logic          clk = 1'b0;
  logic          reset, run, step, imem_ready;
  logic          is_halt, is_branch, stall_req;
  logic [2:0]    state;
  logic          fetch_en, pc_enable, reg_write_enable;
  logic          halted, timeout_err, busy;
  logic [CW-1:0] retired;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(.CNT_WIDTH(CW), .MAX_WAIT(MW)) dut (
    .clk              (clk),
    .reset            (reset),
    .run              (run),
    .step             (step),
    .imem_ready       (imem_ready),
    .is_halt          (is_halt),
    .is_branch        (is_branch),
    .stall_req        (stall_req),
    .state            (state),
    .fetch_en         (fetch_en),
    .pc_enable        (pc_enable),
    .reg_write_enable (reg_write_enable),
    .halted           (halted),
    .timeout_err      (timeout_err),
    .busy             (busy),
    .retired          (retired)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_state"}, 32'(state), 0);
    check({tag, "_fetch"}, 32'(fetch_en), 0);
    check({tag, "_pc"}, 32'(pc_enable), 0);
    check({tag, "_rwe"}, 32'(reg_write_enable), 0);
    check({tag, "_halt"}, 32'(halted), 0);
    check({tag, "_terr"}, 32'(timeout_err), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_ret"}, 32'(retired), 0);
  endtask

  // one unstalled single-step instruction from IDLE
  task automatic step_one(input string tag, input int exp_ret);
    step = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      step = 1'b0;
      check({tag, "_st"}, 32'(state), 32'(i + 1));
    end
    check({tag, "_rwe"}, 32'(reg_write_enable), 1);
    @(negedge clk);
    check({tag, "_idle"}, 32'(state), 0);
    check({tag, "_ret"}, 32'(retired), 32'(exp_ret));
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0; imem_ready = 1'b0;
    is_halt = 1'b0; is_branch = 1'b0; stall_req = 1'b0;
    #2 reset = 1'b0;
    #1 all_zero("rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // free run, 3 instructions
    @(negedge clk);
    check("fr_idle", 32'(state), 0);
    run = 1'b1; imem_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("fr_state", 32'(state), 32'(1 + i % 4));
      check("fr_fetch", 32'(fetch_en), 32'(i % 4 == 0));
      check("fr_pc", 32'(pc_enable), 32'(i % 4 == 3));
      check("fr_ret", 32'(retired), 32'(i / 4));
      if (i == 11) run = 1'b0;
    end
    @(negedge clk);
    check("fr_end_st", 32'(state), 0);
    check("fr_end_ret", 32'(retired), 3);
    check("fr_end_busy", 32'(busy), 0);

    // single step, second step while busy ignored
    step = 1'b1;
    @(negedge clk); check("ss_f", 32'(state), 1); step = 1'b0;
    @(negedge clk); check("ss_d", 32'(state), 2); step = 1'b1;
    @(negedge clk); check("ss_e", 32'(state), 3); step = 1'b0;
    @(negedge clk); check("ss_w", 32'(state), 4);
    check("ss_rwe", 32'(reg_write_enable), 1);
    @(negedge clk); check("ss_i", 32'(state), 0);
    check("ss_ret", 32'(retired), 4);
    repeat (2) @(negedge clk);
    check("ss_park", 32'(state), 0);
    check("ss_ret2", 32'(retired), 4);

    // fetch waits 3 cycles
    step = 1'b1; imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      step = 1'b0;
      check("fw_state", 32'(state), 1);
      check("fw_nofetch", 32'(fetch_en), 0);
      if (i == 3) begin
        imem_ready = 1'b1;
        #1 check("fw_fetch", 32'(fetch_en), 1);
      end
    end
    @(negedge clk); check("fw_d", 32'(state), 2);
    @(negedge clk); check("fw_e", 32'(state), 3);
    @(negedge clk); check("fw_w", 32'(state), 4);
    @(negedge clk); check("fw_i", 32'(state), 0);
    check("fw_ret", 32'(retired), 5);
    check("fw_terr", 32'(timeout_err), 0);

    // fetch timeout
    step = 1'b1; imem_ready = 1'b0;
    for (int i = 0; i < MW; i++) begin
      @(negedge clk);
      step = 1'b0;
      check("to_wait", 32'(state), 1);
    end
    @(negedge clk);
    check("to_state", 32'(state), 6);
    check("to_terr", 32'(timeout_err), 1);
    check("to_busy", 32'(busy), 0);
    run = 1'b1; step = 1'b1; imem_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("to_hold", 32'(state), 6);
    check("to_hold_t", 32'(timeout_err), 1);
    check("to_hold_pc", 32'(pc_enable), 0);
    run = 1'b0; step = 1'b0;
    #2 reset = 1'b0;
    #1 all_zero("to_rst");
    @(negedge clk);
    reset = 1'b1;

    // halt
    is_halt = 1'b1; step = 1'b1;
    @(negedge clk); check("h_f", 32'(state), 1); step = 1'b0;
    @(negedge clk); check("h_d", 32'(state), 2);
    @(negedge clk);
    check("h_state", 32'(state), 5);
    check("h_halted", 32'(halted), 1);
    check("h_rwe", 32'(reg_write_enable), 0);
    check("h_ret", 32'(retired), 0);
    run = 1'b1; step = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      step = (i % 2 == 1);
      check("h_hold", 32'(state), 5);
      check("h_pc", 32'(pc_enable), 0);
    end
    run = 1'b0; step = 1'b0; is_halt = 1'b0;
    #2 reset = 1'b0;
    #1 all_zero("h_rst");
    @(negedge clk);
    reset = 1'b1;

    // branch with 2 stall cycles; stall outside EXECUTE ignored
    step = 1'b1; is_branch = 1'b1; stall_req = 1'b1;
    @(negedge clk); check("b_f", 32'(state), 1); step = 1'b0;
    @(negedge clk); check("b_d", 32'(state), 2);
    @(negedge clk); check("b_e0", 32'(state), 3); is_branch = 1'b0;
    @(negedge clk); check("b_e1", 32'(state), 3);
    @(negedge clk); check("b_e2", 32'(state), 3); stall_req = 1'b0;
    @(negedge clk);
    check("b_w", 32'(state), 4);
    check("b_pc", 32'(pc_enable), 1);
    check("b_rwe", 32'(reg_write_enable), 0);
    @(negedge clk);
    check("b_i", 32'(state), 0);
    check("b_ret", 32'(retired), 1);
    step_one("nb", 2);

    // counter wrap over 16 instructions
    reset = 1'b0;
    #1 reset = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i % 4 == 3) begin
        check("w_pc", 32'(pc_enable), 1);
        check("w_ret", 32'(retired), 32'((i / 4) % 16));
      end
      if (i == 63) run = 1'b0;
    end
    @(negedge clk);
    check("w_idle", 32'(state), 0);
    check("w_wrap", 32'(retired), 0);
    step_one("w1", 1);

    // async reset during EXECUTE
    step = 1'b1;
    @(negedge clk); step = 1'b0;
    @(negedge clk);
    @(negedge clk); check("ar_e", 32'(state), 3);
    #2 reset = 1'b0;
    #1 all_zero("ar");
    @(negedge clk);
    all_zero("ar_hold");
    reset = 1'b1;
    @(negedge clk);
    check("ar_idle", 32'(state), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multicycle control sequencer for the CPU datapath. It replaces the free-running fetch/decode/execute/write-back state counter with an explicit FSM. The FSM adds run/single-step control, an instruction-memory ready handshake with timeout, external execute stalls, halt handling and a retired-instruction counter. It drives the pc controller enable and the register bank write enable.

Parameters:
CNT_WIDTH, 32, width of retired-instruction counter
MAX_WAIT, 16, consecutive not-ready FETCH cycles tolerated before error (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
run  input  1  level; 1 = free-run, 0 = park in IDLE at next instruction boundary
step  input  1  pulse; in IDLE, execute exactly one instruction
imem_ready  input  1  instruction memory output valid for current pc
is_halt  input  1  decoded instruction is halt; sampled in DECODE
is_branch  input  1  decoded instruction is branch; sampled in DECODE
stall_req  input  1  extend EXECUTE by one cycle per asserted cycle
state  output  3  current FSM state encoding
fetch_en  output  1  instruction accepted this cycle
pc_enable  output  1  advance/branch the pc this cycle
reg_write_enable  output  1  commit register bank write this cycle
halted  output  1  halt instruction reached
timeout_err  output  1  sticky fetch timeout flag
busy  output  1  instruction in flight (FETCH..WRITE_BACK)
retired  output  CNT_WIDTH  completed-instruction count, wraps

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITE_BACK=4, HALT=5, ERROR=6. Code 7 is unreachable and recovers to IDLE.
- Reset (reset=0, async):
  - state=IDLE; retired=0; wait_cnt=0; single_step=0; branch_q=0.
  - All outputs 0 immediately, including when reset is asserted mid-instruction.
- IDLE:
  - run=1 -> FETCH, single_step=0.
  - Else step=1 -> FETCH, single_step=1.
  - run dominates when run and step are high together.
- FETCH:
  - wait_cnt clears on entry.
  - imem_ready=1 -> DECODE; fetch_en=1 that cycle (combinational: state==FETCH && imem_ready).
  - imem_ready=0 -> stay and increment wait_cnt.
  - When imem_ready=0 and wait_cnt==MAX_WAIT-1 -> ERROR. This fires on the MAX_WAIT-th consecutive not-ready cycle.
  - Ready has priority over timeout in the same cycle.
- DECODE:
  - branch_q <= is_branch.
  - is_halt=1 -> HALT; else -> EXECUTE.
- EXECUTE: stall_req=1 -> stay; else -> WRITE_BACK.
- WRITE_BACK (always exactly one cycle):
  - pc_enable=1; reg_write_enable = !branch_q.
  - retired <= retired+1, modulo 2^CNT_WIDTH.
  - Next state: single_step=1 or run=0 -> IDLE (clears single_step); else -> FETCH.
- HALT:
  - halted=1, sticky until reset.
  - run and step are ignored; no pc_enable or reg_write_enable.
  - The halting instruction is not counted in retired.
- ERROR: timeout_err=1, sticky until reset; all enables 0.
- Moore outputs, decoded from the state register: pc_enable, reg_write_enable, halted, timeout_err, busy.
  - busy=1 in states 1-4.
- Latency: with no stalls, one instruction takes 4 cycles. An instruction is FETCH->WRITE_BACK, with WRITE_BACK followed directly by FETCH under run.
- step pulses outside IDLE are ignored; they are not queued.
- run deasserted mid-instruction: the instruction completes through WRITE_BACK, then the FSM goes to IDLE.
- stall_req outside EXECUTE is ignored.
- is_halt and is_branch are only sampled in DECODE.

Test Plan:
- Free run: release reset, run=1, imem_ready=1, stall_req=0, 3 instructions -> state 1,2,3,4 repeating. Expect pc_enable and fetch_en each high 1 cycle in 4, and retired=3 after the 12th cycle.
- Single step: run=0, one-cycle step pulse in IDLE -> FETCH..WRITE_BACK once, then IDLE. Expect retired 0->1; a second step while busy has no effect.
- Fetch wait/timeout (MAX_WAIT=16):
  - imem_ready low 3 cycles then high -> FETCH lasts 4 cycles, no error.
  - imem_ready low 16 cycles -> state=6 and timeout_err=1 on the cycle after the 16th. Both hold until reset.
- Halt: is_halt=1 in DECODE -> state=5, halted=1. pc_enable and reg_write_enable stay 0, retired unchanged. Toggling run/step has no effect; reset returns state=0.
- Branch and stall:
  - is_branch=1 in DECODE -> WRITE_BACK with pc_enable=1, reg_write_enable=0.
  - stall_req high 2 cycles -> EXECUTE occupies 3 cycles.
- Wrap and reset: with CNT_WIDTH=4, 16 instructions -> retired=0. Asserting reset low during EXECUTE -> state=0 and all outputs 0 without waiting for a clock edge.
